// File: rtl/io_input_sampler.sv
`default_nettype none
// ============================================================================
// Module      : io_input_sampler
// Description : Bus-readable front end for board inputs (DIP-switch groups and
//               user keys). Each GROUP_W-bit group is synchronised through two
//               flops, debounced by a per-group counter and polarity-normalised.
//               Optional per-group change-pending flags with a masked interrupt
//               are included when IO_SAMPLER_IRQ_EN is defined.
// Ports       : clk_in    - system clock
//               sys_rstn  - asynchronous active-low reset
//               raw_in    - raw pins, group g = raw_in[g*GROUP_W +: GROUP_W]
//               addr      - word address (byte address bits [5:2])
//               we        - write strobe, sampled on rising clk_in
//               wdata     - write data
//               rdata     - combinational read data for addr
//               data_out  - debounced, polarity-normalised inputs
//               irq       - |(pending & mask); constant 0 without the macro
// Config      : IO_SAMPLER_IRQ_EN - implements PENDING (addr 8, W1C),
//               MASK (addr 9, R/W) and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_sampler #(
    parameter int CHANNELS   = 9,
    parameter int GROUP_W    = 8,
    parameter int DEBOUNCE   = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk_in,
    input  logic                        sys_rstn,
    input  logic [CHANNELS*GROUP_W-1:0] raw_in,
    input  logic [3:0]                  addr,
    input  logic                        we,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 rdata,
    output logic [CHANNELS*GROUP_W-1:0] data_out,
    output logic                        irq
);

    localparam int c_total_w = CHANNELS * GROUP_W;
    localparam int c_cnt_w   = $clog2(DEBOUNCE + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE - 1);
    // Level a released (inactive) pin sits at; used as the reset value so that
    // data_out reads 0 out of reset regardless of polarity.
    localparam logic [GROUP_W-1:0] c_idle_grp =
        (ACTIVE_LOW != 0) ? {GROUP_W{1'b1}} : {GROUP_W{1'b0}};

    logic [c_total_w-1:0] r_s1;
    logic [c_total_w-1:0] r_s2;
    logic [c_total_w-1:0] w_stable;
    logic [CHANNELS-1:0]  w_accept;
    logic [255:0]         w_data_pad;
    logic [31:0]          w_pending_word;
    logic [31:0]          w_mask_word;
    logic                 w_unused;

    // Two-flop synchroniser; raw_in reaches nothing else.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_s1 <= {CHANNELS{c_idle_grp}};
            r_s2 <= {CHANNELS{c_idle_grp}};
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
        end
    end

    // Per-group debounce: the synchronised value must differ from the stable
    // value for DEBOUNCE consecutive edges. It may keep changing meanwhile;
    // only a return to the stable value restarts the count.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_grp
        logic [GROUP_W-1:0] r_stable;
        logic [c_cnt_w-1:0] r_cnt;
        logic [GROUP_W-1:0] w_s2_grp;
        logic               w_diff;

        assign w_s2_grp    = r_s2[g*GROUP_W +: GROUP_W];
        assign w_diff      = (w_s2_grp != r_stable);
        assign w_accept[g] = w_diff && (r_cnt == c_cnt_max);

        always_ff @(posedge clk_in or negedge sys_rstn) begin
            if (!sys_rstn) begin
                r_stable <= c_idle_grp;
                r_cnt    <= '0;
            end else if (!w_diff) begin
                r_cnt    <= '0;
            end else if (w_accept[g]) begin
                r_stable <= w_s2_grp;
                r_cnt    <= '0;
            end else begin
                r_cnt    <= r_cnt + 1'b1;
            end
        end

        assign w_stable[g*GROUP_W +: GROUP_W] = r_stable;
    end

    if (ACTIVE_LOW != 0) begin : g_pol_low
        assign data_out = ~w_stable;
    end else begin : g_pol_high
        assign data_out = w_stable;
    end

    // Zero-extend to the full 8-word window so addresses past the last group
    // read 0.
    if (c_total_w < 256) begin : g_pad
        assign w_data_pad = {{(256 - c_total_w){1'b0}}, data_out};
    end else begin : g_nopad
        assign w_data_pad = data_out;
    end

`ifdef IO_SAMPLER_IRQ_EN
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_mask;
    logic                w_wr_pend;
    logic                w_wr_mask;
    logic [CHANNELS-1:0] w_clr;

    assign w_wr_pend = we && (addr == 4'd8);
    assign w_wr_mask = we && (addr == 4'd9);
    assign w_clr     = w_wr_pend ? wdata[CHANNELS-1:0] : '0;

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            // A new accept on the same edge as its W1C keeps the flag set.
            r_pending <= w_accept | (r_pending & ~w_clr);
            if (w_wr_mask) begin
                r_mask <= wdata[CHANNELS-1:0];
            end
        end
    end

    assign irq = |(r_pending & r_mask);

    always_comb begin
        w_pending_word                 = '0;
        w_pending_word[CHANNELS-1:0]   = r_pending;
        w_mask_word                    = '0;
        w_mask_word[CHANNELS-1:0]      = r_mask;
    end

    assign w_unused = &{1'b0, wdata};
`else
    assign irq            = 1'b0;
    assign w_pending_word = '0;
    assign w_mask_word    = '0;
    assign w_unused       = &{1'b0, w_accept, we, wdata};
`endif

    // Side-effect-free combinational read mux.
    always_comb begin
        rdata = '0;
        if (!addr[3]) begin
            rdata = w_data_pad[{addr[2:0], 5'b00000} +: 32];
        end else begin
            case (addr)
                4'd8:    rdata = w_pending_word;
                4'd9:    rdata = w_mask_word;
                default: rdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
